// File: rtl/aes128_cipher_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock, driven by a
// pre-expanded 11-entry round-key schedule, with start/busy/done handshake.
module aes128_cipher_iter #(
    parameter int NR   = 10,
    parameter int KS_W = 1408
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [127:0]    plaintext,
    input  logic [KS_W-1:0] round_keys,
    output logic [127:0]    ciphertext,
    output logic            busy,
    output logic            done
);

    typedef logic [0:15][7:0] blk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic blk_t sub_bytes(input blk_t s);
        blk_t o;
        for (int i = 0; i < 16; i++) begin
            o[4'(i)] = SBOX[s[4'(i)]];
        end
        return o;
    endfunction

    // Row r of the column-major state rotates left by r bytes.
    function automatic blk_t shift_rows(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(4 * c + r)] = s[4'(4 * ((c + r) % 4) + r)];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic blk_t mix_columns(input blk_t s);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(4 * c)];
            a1 = s[4'(4 * c + 1)];
            a2 = s[4'(4 * c + 2)];
            a3 = s[4'(4 * c + 3)];
            o[4'(4 * c)]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4'(4 * c + 1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4'(4 * c + 2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4'(4 * c + 3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    fsm_e                 fsm_q, fsm_d;
    logic [3:0]           rnd_q, rnd_d;
    blk_t                 state_q, state_d;
    logic [0:NR][127:0]   key_q, key_d;
    logic [127:0]         ct_q, ct_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fin_q, fin_d;

    // FINAL spends two edges: the last round into the state register, then the
    // registered output update, so completion lands on the 11th edge after start.
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        key_d   = key_q;
        ct_d    = ct_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fin_d   = fin_q;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    key_d   = round_keys;
                    state_d = plaintext ^ round_keys[KS_W-1 -: 128];
                    rnd_d   = 4'd1;
                    busy_d  = 1'b1;
                    fin_d   = 1'b0;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = mix_columns(shift_rows(sub_bytes(state_q))) ^ key_q[rnd_q];
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == 4'(NR - 1)) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                if (!fin_q) begin
                    state_d = shift_rows(sub_bytes(state_q)) ^ key_q[NR];
                    fin_d   = 1'b1;
                end else begin
                    ct_d   = state_q;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fin_d  = 1'b0;
                    fsm_d  = IDLE;
                end
            end
            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
                fin_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fin_q   <= fin_d;
        end
    end

    assign ciphertext = ct_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_aes128_cipher_iter.sv
// Directed bench for aes128_cipher_iter: FIPS-197 vectors, input isolation,
// back-to-back starts, asynchronous reset and power-on quiet behaviour.
module tb_aes128_cipher_iter;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [127:0]  plaintext;
    logic [1407:0] round_keys;
    logic [127:0]  ciphertext;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int lat;
    int busy_cyc;

    aes128_cipher_iter #(.NR(10), .KS_W(1408)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .round_keys (round_keys),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Stand-in for the upstream KeyExpansion block; round key 0 ends up on top.
    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [127:0]  k;
        logic [1407:0] ks;
        k = key;
        for (int i = 0; i < 4; i++) begin
            w[i] = k[127:96];
            k    = k << 32;
        end
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        ks = '0;
        for (int i = 0; i < 44; i++) begin
            ks = {ks[1375:0], w[i]};
        end
        return ks;
    endfunction

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called just after an edge; returns just after the edge where done is seen.
    task automatic wait_for_done(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic launch(input logic [127:0] pt, input logic [127:0] key);
        plaintext  = pt;
        round_keys = expand_key(key);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        plaintext  = '0;
        round_keys = '0;

        #1;
        check("por_ct", ciphertext, 128'h0);
        check("por_busy", 128'(busy), 128'h0);
        check("por_done", 128'(done), 128'h0);
        #2 rst = 1'b0;

        repeat (50) begin
            @(posedge clk);
            #1;
            check("idle_quiet", 128'({busy, done}), 128'h0);
        end

        launch(PT_B, KEY_B);
        wait_for_done(lat, busy_cyc);
        check("appb_latency", 128'(lat), 128'd11);
        check("appb_busy_cycles", 128'(busy_cyc), 128'd11);
        check("appb_ct", ciphertext, CT_B);
        check("appb_busy_low", 128'(busy), 128'h0);
        @(posedge clk);
        #1;
        check("appb_done_pulse", 128'(done), 128'h0);
        check("appb_ct_held", ciphertext, CT_B);

        launch(PT_C, KEY_C);
        wait_for_done(lat, busy_cyc);
        check("appc_latency", 128'(lat), 128'd11);
        check("appc_ct", ciphertext, CT_C);
        @(posedge clk);
        #1;
        check("appc_done_pulse", 128'(done), 128'h0);

        launch(PT_B, KEY_B);
        plaintext  = {$urandom(), $urandom(), $urandom(), $urandom()};
        round_keys = expand_key({$urandom(), $urandom(), $urandom(), $urandom()});
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("iso_busy_mid", 128'(busy), 128'h1);
        wait_for_done(lat, busy_cyc);
        check("iso_latency_from_e5", 128'(lat), 128'd6);
        check("iso_ct", ciphertext, CT_B);
        repeat (15) begin
            @(posedge clk);
            #1;
            check("iso_no_second_block", 128'({busy, done}), 128'h0);
        end

        plaintext  = PT_B;
        round_keys = expand_key(KEY_B);
        start      = 1'b1;
        @(posedge clk);
        #1;
        wait_for_done(lat, busy_cyc);
        check("b2b_first_latency", 128'(lat), 128'd11);
        check("b2b_first_ct", ciphertext, CT_B);
        plaintext  = PT_C;
        round_keys = expand_key(KEY_C);
        @(posedge clk);
        #1;
        check("b2b_done_low", 128'(done), 128'h0);
        check("b2b_restart_busy", 128'(busy), 128'h1);
        wait_for_done(lat, busy_cyc);
        start = 1'b0;
        check("b2b_second_latency", 128'(lat), 128'd11);
        check("b2b_second_ct", ciphertext, CT_C);
        @(posedge clk);
        #1;
        check("b2b_stop", 128'({busy, done}), 128'h0);

        launch(PT_B, KEY_B);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_done", 128'(done), 128'h0);
        check("rst_ct", ciphertext, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("rst_no_stale_done", 128'({busy, done}), 128'h0);
        end
        launch(PT_C, KEY_C);
        wait_for_done(lat, busy_cyc);
        check("post_rst_latency", 128'(lat), 128'd11);
        check("post_rst_ct", ciphertext, CT_C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
